mult_sched: RTL
===============

Name: mult_sched

Overview:
- Shares one pipelined array multiplier (fixed latency LAT, no stall input) between NREQ requesters.
- Round-robin arbitration selects one request per cycle and drives the multiplier operands.
- A requester ID travels alongside each operation in a LAT-deep tag pipe.
- Results land in a response FIFO with a ready/valid handshake. Credit-based issue guarantees the FIFO never overflows, so the multiplier never needs to stall.

Parameters:
- WIDTH, 16, operand width; product width is 2*WIDTH.
- NREQ, 4, number of requesters (≥2).
- LAT, 9, multiplier latency in clk cycles from operand capture to product valid.
- DEPTH, 12, response FIFO depth (≥LAT+1).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*WIDTH  packed operand B.
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
- mul_a  out  WIDTH  operand A to multiplier, registered.
- mul_b  out  WIDTH  operand B to multiplier, registered.
- mul_y  in  2*WIDTH  product from multiplier, valid LAT cycles after mul_a/mul_b update.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  requester ID of head response.
- rsp_y  out  2*WIDTH  product at head of FIFO.
- busy  out  1  any op in flight or FIFO non-empty.

Behaviour:
- Reset (async assert, sync deassert internally): req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, tag pipe valids=0, credit=DEPTH, rr pointer=0, FIFO empty.
- Grant:
  - req_ready is combinational from req_valid, credit and the rr pointer.
  - At most one bit set.
  - Grant only if credit>0.
  - Search starts at pointer, wraps modulo NREQ.
- Issue (cycle N, grant to i):
  - mul_a/mul_b <= slice i at N+1.
  - Tag pipe stage0 <= {1,i}.
  - Pointer <= (i+1) mod NREQ.
  - Credit decrements.
  - No grant: mul_a/mul_b hold their value; stage0 valid=0; pointer holds.
- Tag pipe: LAT-stage shift register of {valid,id}. When the last stage is valid, {id, mul_y} is pushed into the FIFO that cycle.
- Latency: request accepted at edge N → rsp_valid=1 at edge N+LAT+1 when the FIFO was empty.
- FIFO:
  - Circular, DEPTH entries; wrap-around on read/write pointers.
  - rsp_y/rsp_id show head entry; pop on rsp_valid&rsp_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full (pop frees the slot first) and when empty with no bypass (push visible the next cycle).
- Credit:
  - Decrements on issue, increments on pop; both in the same cycle → unchanged.
  - Invariant: credit + in-flight + FIFO count == DEPTH. Credit is never <0 or >DEPTH.
  - Credit=0 blocks all grants; req_valid may stay high indefinitely, and other requests are unaffected once credit returns.
- Fairness: with all requesters continuously valid and credit available, grant order is 0,1,2,3,0,…
- Reset mid-operation drops all in-flight and buffered results; no response appears after deassertion.
- Widths: IDs are zero-extended; mul_y is taken unmodified.

Optional Feature:
- Macro MULT_SCHED_PERF_EN.
- When defined:
  - Adds output perf_issue (32 bits, total issues, wraps at 2^32).
  - Adds output perf_stall (32 bits, cycles with any req_valid but credit==0).
  - Both reset to 0.
- When undefined, neither port nor counter exists.

Decomposition:
- Package mult_sched_pkg holds default WIDTH/NREQ/LAT/DEPTH constants and the tag typedef {valid, id}.
- One sub-module, mult_sched_rr_arb: NREQ-bit round-robin arbiter with pointer register, request mask input and one-hot grant.
- FIFO and credit counter stay inline.

Test Plan:
- Single request: requester 2, a=3, b=5, rsp_ready=1 → rsp_valid at cycle LAT+1 after acceptance, rsp_id=2, rsp_y=15, busy returns to 0.
- All four valid continuously, a=i+1, b=10 → grants 0,1,2,3 repeated; responses in the same order with y=10,20,30,40.
- rsp_ready=0, requester 0 always valid → exactly DEPTH(12) accepts, then req_ready=0. Raise rsp_ready for one cycle → one pop, one new grant, credit never below 0.
- FIFO full with simultaneous push and pop → count stays 12, no lost or duplicated result, wrap-around order preserved.
- Maximum operands a=b=16'hFFFF → rsp_y=32'hFFFE0001.
- Assert rst_n=0 with 5 ops in flight → all outputs at reset values; after release, no stale rsp_valid and credit=12.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared constants and tag type for the mult_sched shared-multiplier scheduler.
package mult_sched_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_LAT   = 9;
  localparam int DEF_DEPTH = 12;
  localparam int TAG_IDW   = $clog2(DEF_NREQ);

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module mult_sched_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] ptr_r;
  logic           found_s;
  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;

  // Scan requesters starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(NREQ)) begin
        sum_s = sum_s - (IDW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDW-1:0];
      if (!found_s && req[idx_s] && mask[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_id     = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register: next search starts just after the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters with credit-guarded response FIFO.
// Optional performance counters are enabled by defining MULT_SCHED_PERF_EN.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_y,
  output logic                  busy
`ifdef MULT_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_issue,
  output logic [31:0]           perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  logic                 run_r;
  logic [CW-1:0]        credit_r;
  logic [NREQ-1:0]      mask_s;
  logic [NREQ-1:0]      grant_s;
  logic [IDW-1:0]       grant_id_s;
  logic                 issue_s;
  tag_t                 issue_tag_r;
  tag_t                 tag_pipe_r [LAT];
  logic                 push_s;
  logic                 pop_s;
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [IDW-1:0]       id_mem_r [DEPTH];
  logic [2*WIDTH-1:0]   y_mem_r  [DEPTH];

  // Grants stay off until the first edge after reset release (synchronous deassertion).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  assign mask_s  = {NREQ{run_r && (credit_r != '0)}};
  assign issue_s = |grant_s;

  mult_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .mask     (mask_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  assign req_ready = grant_s;

  // Operand registers hold their value when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (issue_s) begin
      mul_a <= req_a[grant_id_s*WIDTH +: WIDTH];
      mul_b <= req_b[grant_id_s*WIDTH +: WIDTH];
    end else begin
      mul_a <= mul_a;
      mul_b <= mul_b;
    end
  end

  // issue_tag_r rides with mul_a; the LAT stages behind it line up with mul_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_tag_r <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_pipe_r[k] <= '0;
      end
    end else begin
      issue_tag_r   <= {issue_s, TAG_IDW'(grant_id_s)};
      tag_pipe_r[0] <= issue_tag_r;
      for (int k = 1; k < LAT; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  assign push_s    = tag_pipe_r[LAT-1].valid;
  assign rsp_valid = (count_r != '0);
  assign pop_s     = rsp_valid && rsp_ready;

  // Response storage; no reset needed since outputs are gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      id_mem_r[wr_ptr_r] <= IDW'(tag_pipe_r[LAT-1].id);
      y_mem_r[wr_ptr_r]  <= mul_y;
    end
  end

  // FIFO pointers, occupancy and issue credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      credit_r <= CW'(DEPTH);
    end else begin
      wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      case ({issue_s, pop_s})
        2'b10:   credit_r <= credit_r - CW'(1);
        2'b01:   credit_r <= credit_r + CW'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  assign rsp_id = rsp_valid ? id_mem_r[rd_ptr_r] : '0;
  assign rsp_y  = rsp_valid ? y_mem_r[rd_ptr_r]  : '0;
  // Outstanding work exists exactly when some credit is lent out.
  assign busy   = (credit_r != CW'(DEPTH));

`ifdef MULT_SCHED_PERF_EN
  // Issue and credit-stall event counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      perf_issue <= issue_s ? perf_issue + 32'd1 : perf_issue;
      perf_stall <= ((|req_valid) && (credit_r == '0)) ? perf_stall + 32'd1 : perf_stall;
    end
  end
`endif

endmodule
